regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback stage and a multi-cycle auxiliary unit (mul/div result path). Auxiliary results are buffered in a small FIFO and drained into idle writeback slots. A per-read-port scoreboard flags registers with a queued, not-yet-committed auxiliary write so hazard logic can stall. Sits between the WB stage / aux unit and the register file write inputs (we, writeRegister, writeData).

Parameters:
FIFO_DEPTH, 4, auxiliary write-buffer entries (power of two, >=2)
ADDR_W, 5, register address width
DATA_W, 32, register data width
STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO head may be blocked before stall_req is raised

Ports:
clk  in  1  clock
rst  in  1  reset
wb_we  in  1  pipeline writeback request
wb_addr  in  ADDR_W  pipeline destination register
wb_data  in  DATA_W  pipeline write data
aux_valid  in  1  aux result valid
aux_ready  out  1  aux result accepted this cycle when high with aux_valid
aux_addr  in  ADDR_W  aux destination register
aux_data  in  DATA_W  aux result
rf_we  out  1  register-file write enable (registered)
rf_addr  out  ADDR_W  register-file write address (registered)
rf_data  out  DATA_W  register-file write data (registered)
rd_addr1  in  ADDR_W  scoreboard query, read port 1
rd_addr2  in  ADDR_W  scoreboard query, read port 2
rd_pending1  out  1  rd_addr1 has an uncommitted aux write
rd_pending2  out  1  rd_addr2 has an uncommitted aux write
stall_req  out  1  request that the pipeline leave the next WB slot empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
err  out  1  sticky protocol-error flag

Behaviour:
- Reset is synchronous and active-low on rst, with clock clk. On reset: FIFO emptied, fifo_count=0, rf_we=0, rf_addr=0, rf_data=0, stall_req=0, starvation counter=0, err=0.
- aux_ready = rst && (fifo_count != FIFO_DEPTH). It is combinational and is 0 while in reset.
- Enqueue: when aux_valid && aux_ready, push {aux_addr, aux_data}. If aux_addr==0, accept the result but discard it; no entry is written.
- Arbitration, evaluated each cycle, result registered on the next edge (1-cycle latency):
  - If wb_we && wb_addr!=0: WB wins. Output the WB write; no pop.
  - Else if FIFO is non-empty: pop the head and output it as rf_we=1.
  - Else: rf_we=0. rf_addr and rf_data hold their previous values.
- A WB write to register 0 counts as no request; the slot goes to the FIFO.
- Simultaneous enqueue and pop in the same cycle are both allowed. With a full FIFO, the pop does not free aux_ready in the same cycle.
- Read/write pointers wrap modulo FIFO_DEPTH. FIFO order is strict; aux writes are never reordered among themselves.
- Scoreboard: rd_pendingN=1 when rd_addrN!=0 and it matches any valid FIFO entry, or matches rf_addr while rf_we=1. Purely combinational.
- The block does not order WB writes against queued aux writes to the same register. The pipeline must use rd_pending to avoid issuing such a WB.
- Reset mid-operation drops all queued entries silently.
- err is set sticky if wb_we=1 with wb_addr!=0 while stall_req=1.

Optional Feature:
Macro STARVE_GUARD_EN.
- With it defined: a counter increments every cycle the FIFO is non-empty and the slot goes to WB, and clears on any pop.
  - When the counter reaches STARVE_LIMIT, stall_req is registered high for exactly one cycle.
  - In that cycle the pipeline must hold wb_we=0. The FIFO head drains and the counter clears.
  - If WB writes anyway, WB still wins and err is set.
- Without it: no counter, stall_req tied 0, err never set.

Test Plan:
- Reset: rst=0 for 2 cycles with aux_valid=1 -> aux_ready=0, rf_we=0, fifo_count=0, err=0 after release.
- WB only: wb_we=1, wb_addr=5, wb_data=0xDEAD_BEEF -> next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF; fifo_count stays 0.
- Fill and drain: 4 aux pushes (addr 1..4) under continuous WB writes -> fifo_count=4, aux_ready=0, rd_pending1=1 for rd_addr1=3; drop WB -> writes 1,2,3,4 appear in order on consecutive cycles, then rf_we=0.
- Simultaneous: FIFO holds 1 entry, idle WB, aux push addr 7 in same cycle -> head popped, fifo_count stays 1, head now addr 7.
- Zero register: aux_addr=0 push, and wb_addr=0 with wb_we=1 -> nothing enqueued; no rf_we for address 0; queued head drains in the WB slot.
- STARVE_GUARD_EN: 1 queued entry, wb_we=1 every cycle -> stall_req high one cycle after 8 blocked cycles; with wb_we=0 that cycle, the entry commits next cycle; repeat with wb_we=1 -> err=1 and stays set.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle for regfile_write_arbiter: writeback request, auxiliary result
// handshake, register-file write port, scoreboard queries and status.
// The slave modport is the arbiter's view; master is the surrounding
// pipeline / register-file view.
interface regfile_write_arbiter_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32
);
  // pipeline writeback stage
  logic                        wb_we;
  logic [ADDR_W-1:0]           wb_addr;
  logic [DATA_W-1:0]           wb_data;
  // auxiliary (mul/div) result path
  logic                        aux_valid;
  logic                        aux_ready;
  logic [ADDR_W-1:0]           aux_addr;
  logic [DATA_W-1:0]           aux_data;
  // register-file write port
  logic                        rf_we;
  logic [ADDR_W-1:0]           rf_addr;
  logic [DATA_W-1:0]           rf_data;
  // hazard scoreboard queries
  logic [ADDR_W-1:0]           rd_addr1;
  logic [ADDR_W-1:0]           rd_addr2;
  logic                        rd_pending1;
  logic                        rd_pending2;
  // status
  logic                        stall_req;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        err;

  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  aux_valid, aux_addr, aux_data,
    output aux_ready,
    output rf_we, rf_addr, rf_data,
    input  rd_addr1, rd_addr2,
    output rd_pending1, rd_pending2,
    output stall_req, fifo_count, err
  );

  modport master (
    output wb_we, wb_addr, wb_data,
    output aux_valid, aux_addr, aux_data,
    input  aux_ready,
    input  rf_we, rf_addr, rf_data,
    output rd_addr1, rd_addr2,
    input  rd_pending1, rd_pending2,
    input  stall_req, fifo_count, err
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single register-file write port between
// the in-order writeback stage and a multi-cycle auxiliary unit. Aux results
// queue in a small FIFO and drain into idle writeback slots; a scoreboard
// flags registers that still have an uncommitted aux write.
// Optional build macro STARVE_GUARD_EN: adds a starvation counter that
// requests one empty WB slot after STARVE_LIMIT blocked cycles and a sticky
// err flag when the pipeline ignores that request.
// Reset rst is synchronous, active-low.
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // FIFO storage (data path, never reset) and control state
  logic [ADDR_W-1:0]     addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]     data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] slot_vld;
  logic [FIFO_DEPTH-1:0] slot_vld_nxt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nxt;

  // stage p0: combinational arbitration decision
  logic                  aux_ready_p0;
  logic                  push_p0;
  logic                  wb_req_p0;
  logic                  empty_p0;
  logic                  pop_p0;
  logic [ADDR_W-1:0]     head_addr_p0;
  logic [DATA_W-1:0]     head_data_p0;

  // stage p1: registered register-file write
  logic                  vld_p1;
  logic [ADDR_W-1:0]     addr_p1;
  logic [DATA_W-1:0]     data_p1;

  // starvation guard outputs (constant when the guard is not built)
  logic                  stall_q;
  logic                  err_q;

  // scoreboard hits
  logic                  hit1;
  logic                  hit2;

  // ---- stage p0 ----
  assign aux_ready_p0 = rst && (count != FULL_CNT);
  // results for register 0 are accepted but never stored
  assign push_p0      = bus.aux_valid && aux_ready_p0 && (bus.aux_addr != '0);
  // a writeback to register 0 is treated as an idle slot
  assign wb_req_p0    = bus.wb_we && (bus.wb_addr != '0);
  assign empty_p0     = (count == '0);
  assign pop_p0       = !wb_req_p0 && !empty_p0;
  assign head_addr_p0 = addr_mem[rd_ptr];
  assign head_data_p0 = data_mem[rd_ptr];

  // Next-state occupancy bitmap and count; push and pop never hit the same
  // slot because a pop needs a non-empty FIFO and a push needs a non-full one.
  always_comb begin
    slot_vld_nxt = slot_vld;
    if (pop_p0)
      slot_vld_nxt[rd_ptr] = 1'b0;
    if (push_p0)
      slot_vld_nxt[wr_ptr] = 1'b1;
    case ({push_p0, pop_p0})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO control: pointers wrap naturally modulo the power-of-two depth
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      slot_vld <= '0;
    end else begin
      if (push_p0)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_p0)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_nxt;
      slot_vld <= slot_vld_nxt;
    end
  end

  // FIFO payload write; push is already qualified by reset via aux_ready
  always_ff @(posedge clk) begin
    if (push_p0) begin
      addr_mem[wr_ptr] <= bus.aux_addr;
      data_mem[wr_ptr] <= bus.aux_data;
    end
  end

  // ---- stage p1 ----
  // Register-file write register: WB has priority, otherwise drain the FIFO
  // head; address and data hold when the slot is idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else if (wb_req_p0) begin
      vld_p1  <= 1'b1;
      addr_p1 <= bus.wb_addr;
      data_p1 <= bus.wb_data;
    end else if (pop_p0) begin
      vld_p1  <= 1'b1;
      addr_p1 <= head_addr_p0;
      data_p1 <= head_data_p0;
    end else begin
      vld_p1  <= 1'b0;
    end
  end

`ifdef STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_cnt;
  logic            blocked_p0;

  assign blocked_p0 = wb_req_p0 && !empty_p0;

  // Starvation counter: counts blocked head cycles, raises stall_req for one
  // cycle on reaching the limit, and restarts after any pop or stall slot so
  // a pipeline that ignores the stall gets asked again later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (pop_p0 || stall_q)
        starve_cnt <= '0;
      else if (blocked_p0)
        starve_cnt <= starve_cnt + SC_W'(1);
      stall_q <= blocked_p0 && !stall_q &&
                 (starve_cnt == SC_W'(STARVE_LIMIT - 1));
      if (stall_q && wb_req_p0)
        err_q <= 1'b1;
    end
  end
`else
  // Without the guard there is never a stall or a protocol error; the limit
  // parameter is folded in only so it stays referenced in this build.
  assign stall_q = 1'b0 & (STARVE_LIMIT == 0);
  assign err_q   = 1'b0;
`endif

  // Scoreboard: a register is pending while queued or while its write is
  // sitting in the output register; register 0 is never pending.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (slot_vld[i] && (addr_mem[i] == bus.rd_addr1))
        hit1 = 1'b1;
      if (slot_vld[i] && (addr_mem[i] == bus.rd_addr2))
        hit2 = 1'b1;
    end
    if (vld_p1 && (addr_p1 == bus.rd_addr1))
      hit1 = 1'b1;
    if (vld_p1 && (addr_p1 == bus.rd_addr2))
      hit2 = 1'b1;
  end

  assign bus.aux_ready   = aux_ready_p0;
  assign bus.rf_we       = vld_p1;
  assign bus.rf_addr     = addr_p1;
  assign bus.rf_data     = data_p1;
  assign bus.rd_pending1 = hit1 && (bus.rd_addr1 != '0);
  assign bus.rd_pending2 = hit2 && (bus.rd_addr2 != '0);
  assign bus.stall_req   = stall_q;
  assign bus.fifo_count  = count;
  assign bus.err         = err_q;

endmodule
